// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin scheduler sharing one 3-bit decoder select among 8 requesters
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   synchronous active-low reset
//   req        in   [7:0] level requests, bit i = channel i
//   release_i  in   owner done, only looked at while granting
//   sel        out  [2:0] index of the granted channel (held after tenure ends)
//   grant      out  [7:0] one-hot grant, zero outside a tenure
//   grant_vld  out  high while a tenure is active
//   timeout    out  one-cycle pulse after a tenure ended by the hold timer
module rr_sel_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] req,
   input  logic       release_i,
   output logic [2:0] sel,
   output logic [7:0] grant,
   output logic       grant_vld,
   output logic       timeout
);
   typedef enum logic [1:0] {IDLE, ARB, GRANT, GAP} state_t;
   state_t           state_q;
   logic [2:0]       sel_q, last_ptr_q, win_d, idx;
   logic [7:0]       grant_q;
   logic             vld_q, timeout_q, hold_end, exit_d;
   logic [CNT_W-1:0] hold_cnt_q;
   // Scan from farthest to nearest so the channel right after the last owner wins.
   always_comb begin
      win_d = last_ptr_q;
      idx   = '0;
      for (int k = 8; k >= 1; k--) begin
         idx = last_ptr_q + 3'(k);
         if (req[idx]) win_d = idx;
      end
      hold_end = hold_cnt_q == CNT_W'(MAX_HOLD - 1);
      exit_d   = release_i | ~req[sel_q] | hold_end;
   end
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         grant_q    <= '0;
         vld_q      <= 1'b0;
         timeout_q  <= 1'b0;
         hold_cnt_q <= '0;
         last_ptr_q <= 3'd7;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: if (|req) state_q <= ARB;
            ARB: begin
               if (|req) begin
                  sel_q      <= win_d;
                  grant_q    <= 8'b1 << win_d;
                  vld_q      <= 1'b1;
                  hold_cnt_q <= '0;
                  last_ptr_q <= win_d;
                  state_q    <= GRANT;
               end else state_q <= IDLE;
            end
            GRANT: begin
               hold_cnt_q <= hold_cnt_q + 1'b1;
               if (exit_d) begin
                  grant_q   <= '0;
                  vld_q     <= 1'b0;
                  // Timer only counts as the cause when neither release nor request drop applies.
                  timeout_q <= ~release_i & req[sel_q] & hold_end;
                  state_q   <= GAP;
               end
            end
            GAP: state_q <= (|req) ? ARB : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign sel       = sel_q;
   assign grant     = grant_q;
   assign grant_vld = vld_q;
   assign timeout   = timeout_q;
endmodule
